// File: rtl/gpio_led_ctrl.sv
// Per-channel LED driver (off/direct/PWM/blink), optional sticky trap blink via GPIO_LED_CTRL_TRAP_OVERRIDE_EN.
// Latency: gpio_i->led_o 1 cycle, config write->led_o 2 cycles; no backpressure, every write accepted.
module gpio_led_ctrl #(
  parameter int              N_CH         = 5,
  parameter int              PWM_BITS     = 8,
  parameter int              PRESCALE_DIV = 125000,
  parameter logic [N_CH-1:0] INV_MASK     = 5'b01100,
  parameter int              TRAP_HALF    = 250
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        wr_en_i,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  wr_ch_i,
  input  logic [PWM_BITS+1:0]                         wr_data_i,
  input  logic [N_CH-1:0]                             gpio_i,
  input  logic                                        trap_i,
  output logic [N_CH-1:0]                             led_o,
  output logic                                        trap_o
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_DIRECT = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // Field order matches wr_data_i: level in the upper bits, mode in [1:0].
  typedef struct packed {
    logic [PWM_BITS-1:0] level;
    mode_e               mode;
  } cfg_t;

  localparam int              PS_W   = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE_DIV - 1);

  cfg_t [N_CH-1:0]                cfg_q, cfg_d;
  logic [N_CH-1:0][PWM_BITS-1:0]  blink_cnt_q, blink_cnt_d;
  logic [N_CH-1:0]                phase_q, phase_d;
  logic [PWM_BITS-1:0]            pwm_cnt_q;
  logic [PS_W-1:0]                presc_q;
  logic [N_CH-1:0]                led_q;
  logic [N_CH-1:0]                chan_active;
  logic [N_CH-1:0]                final_active;
  logic                           tick;
  logic                           wr_hit;
  cfg_t                           wr_cfg;

  assign tick   = (presc_q == PS_MAX);
  assign wr_hit = wr_en_i && (int'(wr_ch_i) < N_CH);
  assign wr_cfg = cfg_t'(wr_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= tick ? '0 : presc_q + PS_W'(1);
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  // A write to a channel takes priority over that channel's blink tick.
  always_comb begin
    cfg_d       = cfg_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (cfg_q[ch].mode == MODE_BLINK && tick) begin
        if (blink_cnt_q[ch] == cfg_q[ch].level) begin
          blink_cnt_d[ch] = '0;
          phase_d[ch]     = ~phase_q[ch];
        end else begin
          blink_cnt_d[ch] = blink_cnt_q[ch] + PWM_BITS'(1);
        end
      end
      if (wr_hit && int'(wr_ch_i) == ch) begin
        cfg_d[ch] = wr_cfg;
        if (wr_cfg.mode == MODE_BLINK) begin
          blink_cnt_d[ch] = '0;
          phase_d[ch]     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    chan_active = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      case (cfg_q[ch].mode)
        MODE_OFF:    chan_active[ch] = 1'b0;
        MODE_DIRECT: chan_active[ch] = gpio_i[ch];
        MODE_PWM:    chan_active[ch] = (pwm_cnt_q < cfg_q[ch].level);
        MODE_BLINK:  chan_active[ch] = phase_q[ch];
      endcase
    end
  end

`ifdef GPIO_LED_CTRL_TRAP_OVERRIDE_EN
  localparam int              TR_W   = (TRAP_HALF > 1) ? $clog2(TRAP_HALF) : 1;
  localparam logic [TR_W-1:0] TR_MAX = TR_W'(TRAP_HALF - 1);

  logic            trap_q, trap_d;
  logic [TR_W-1:0] trap_cnt_q, trap_cnt_d;
  logic            trap_phase_q, trap_phase_d;

  // The trap blink counter stays parked at zero until the flag latches.
  always_comb begin
    trap_d       = trap_q | trap_i;
    trap_cnt_d   = trap_cnt_q;
    trap_phase_d = trap_phase_q;
    if (trap_q && tick) begin
      if (trap_cnt_q == TR_MAX) begin
        trap_cnt_d   = '0;
        trap_phase_d = ~trap_phase_q;
      end else begin
        trap_cnt_d = trap_cnt_q + TR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trap_q       <= 1'b0;
      trap_cnt_q   <= '0;
      trap_phase_q <= 1'b0;
    end else begin
      trap_q       <= trap_d;
      trap_cnt_q   <= trap_cnt_d;
      trap_phase_q <= trap_phase_d;
    end
  end

  assign final_active = trap_q ? {N_CH{trap_phase_q}} : chan_active;
  assign trap_o       = trap_q;
`else
  logic unused_trap;
  assign unused_trap  = trap_i & (TRAP_HALF > 0);
  assign final_active = chan_active;
  assign trap_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= '0;
      led_q       <= INV_MASK;
    end else begin
      cfg_q       <= cfg_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= final_active ^ INV_MASK;
    end
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Bench for gpio_led_ctrl: directed vector table, hand-written corner sequences and random stimulus
// checked against a time-based model (pwm/prescaler/blink/trap phases derived from cycle counts).
module tb_gpio_led_ctrl;

  localparam int         N_CH         = 5;
  localparam int         PWM_BITS     = 4;
  localparam int         PRESCALE_DIV = 4;
  localparam int         TRAP_HALF    = 2;
  localparam logic [4:0] INV          = 5'b01100;
`ifdef GPIO_LED_CTRL_TRAP_OVERRIDE_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_en_i = 1'b0;
  logic [2:0] wr_ch_i = '0;
  logic [5:0] wr_data_i = '0;
  logic [4:0] gpio_i = '0;
  logic       trap_i = 1'b0;
  logic [4:0] led_o;
  logic       trap_o;

  gpio_led_ctrl #(
    .N_CH(N_CH), .PWM_BITS(PWM_BITS), .PRESCALE_DIV(PRESCALE_DIV),
    .INV_MASK(INV), .TRAP_HALF(TRAP_HALF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_ch_i(wr_ch_i),
    .wr_data_i(wr_data_i), .gpio_i(gpio_i), .trap_i(trap_i),
    .led_o(led_o), .trap_o(trap_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cur = clock edges since reset release; eff_m = first state a config applies in.
  int cur;
  int mode_m [N_CH];
  int level_m[N_CH];
  int eff_m  [N_CH];
  int trap_st;

  typedef struct {
    logic       we;
    logic [2:0] ch;
    logic [5:0] dat;
    logic [4:0] gp;
    logic [4:0] exp_led;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur);
    end
  endtask

  // Number of states j in [a,b] during which the prescaler emits its tick.
  function automatic int ticks_between(input int a, input int b);
    if (b < a) return 0;
    return (b + 1) / PRESCALE_DIV - a / PRESCALE_DIV;
  endfunction

  function automatic logic [4:0] model_led(input logic [4:0] gp);
    logic [4:0] act;
    act = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      case (mode_m[ch])
        1: act[ch] = gp[ch];
        2: act[ch] = ((cur % (1 << PWM_BITS)) < level_m[ch]);
        3: act[ch] = ((ticks_between(eff_m[ch], cur - 1) / (level_m[ch] + 1)) % 2) == 1;
        default: act[ch] = 1'b0;
      endcase
    end
    if (TRAP_EN && trap_st >= 0 && trap_st <= cur)
      act = {5{((ticks_between(trap_st, cur - 1) / TRAP_HALF) % 2) == 1}};
    return act ^ INV;
  endfunction

  task automatic step(input logic we, input logic [2:0] ch, input logic [5:0] dat,
                      input logic [4:0] gp, input logic tr);
    logic [4:0] exp_led;
    logic       exp_trap;
    wr_en_i = we; wr_ch_i = ch; wr_data_i = dat; gpio_i = gp; trap_i = tr;
    exp_led = model_led(gp);
    if (we && ch < N_CH) begin
      mode_m[ch]  = int'(dat[1:0]);
      level_m[ch] = int'(dat[5:2]);
      eff_m[ch]   = cur + 1;
    end
    if (TRAP_EN && tr && trap_st < 0) trap_st = cur + 1;
    exp_trap = TRAP_EN && (trap_st >= 0);
    @(posedge clk_i);
    #1;
    cur++;
    check("model_led", led_o, exp_led);
    check("model_trap", trap_o, exp_trap);
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 6'd0, 5'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; wr_en_i = 1'b0; trap_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    cur = 0; trap_st = -1;
    for (int ch = 0; ch < N_CH; ch++) begin
      mode_m[ch] = 0; level_m[ch] = 0; eff_m[ch] = 0;
    end
    check("reset_led", led_o, INV);
    check("reset_trap", trap_o, 1'b0);
  endtask

  initial begin
    int cnt;
    int run;
    bit found;
    int pwm_lv[3];
    logic [4:0] x;

    // {we, ch, data={level,mode}, gpio, expected led_o after the edge}
    tbl[0] = '{1'b1, 3'd0, 6'b000001, 5'b00000, 5'b01100};
    tbl[1] = '{1'b1, 3'd2, 6'b000001, 5'b00001, 5'b01101};
    tbl[2] = '{1'b0, 3'd0, 6'b000000, 5'b00101, 5'b01001};
    tbl[3] = '{1'b1, 3'd6, 6'b000001, 5'b11111, 5'b01001};
    tbl[4] = '{1'b0, 3'd0, 6'b000000, 5'b11010, 5'b01100};
    tbl[5] = '{1'b1, 3'd0, 6'b000000, 5'b00001, 5'b01101};
    tbl[6] = '{1'b0, 3'd0, 6'b000000, 5'b00001, 5'b01100};
    tbl[7] = '{1'b0, 3'd0, 6'b000000, 5'b00100, 5'b01000};
    pwm_lv = '{5, 0, 15};

    do_reset();
    for (int i = 0; i < 100; i++) begin
      idle();
      check("idle_led", led_o, INV);
    end

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].ch, tbl[i].dat, tbl[i].gp, 1'b0);
      check("table_led", led_o, tbl[i].exp_led);
    end

    // PWM duty over one full 16-cycle period
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd1, {4'(pwm_lv[k]), 2'd2}, 5'($urandom), 1'b0);
      idle();
      cnt = int'(led_o[1]);
      repeat (15) begin
        idle();
        cnt += int'(led_o[1]);
      end
      check("pwm_duty", cnt, pwm_lv[k]);
    end

    // Blink level 1 on inverted ch3: 8-cycle half periods, rewrite restarts inactive
    step(1'b1, 3'd3, {4'd1, 2'd3}, 5'($urandom), 1'b0);
    idle();
    check("blink_start_inactive", led_o[3], 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle();
      if (led_o[3] == 1'b0) found = 1'b1;
    end
    check("blink_goes_active", found, 1'b1);
    run = 0;
    while (led_o[3] == 1'b0 && run < 20) begin
      idle();
      run++;
    end
    check("blink_half_period", run, 8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle();
      if (led_o[3] == 1'b0) found = 1'b1;
    end
    check("blink_goes_active_again", found, 1'b1);
    repeat (3) idle();
    step(1'b1, 3'd3, {4'd1, 2'd3}, 5'($urandom), 1'b0);
    idle();
    check("blink_restart", led_o[3], 1'b1);
    repeat (20) idle();

    // Random writes (including out-of-range channels) and gpio
    do_reset();
    repeat (3000)
      step(($urandom % 4) == 0, 3'($urandom_range(0, 7)), 6'($urandom), 5'($urandom), 1'b0);

    // Trap pulse coinciding with a config write
    do_reset();
    step(1'b1, 3'd0, 6'b000001, 5'($urandom), 1'b0);
    step(1'b1, 3'd1, {4'd7, 2'd2}, 5'($urandom), 1'b0);
    step(1'b1, 3'd3, {4'd0, 2'd3}, 5'($urandom), 1'b0);
    repeat (10) idle();
    step(1'b1, 3'd4, {4'd3, 2'd2}, 5'($urandom), 1'b1);
`ifdef GPIO_LED_CTRL_TRAP_OVERRIDE_EN
    check("trap_o_set", trap_o, 1'b1);
    idle();
    check("trap_led_inactive", led_o, INV);
    for (int i = 0; i < 40; i++) begin
      step(($urandom % 3) == 0, 3'($urandom_range(0, 4)), 6'($urandom), 5'($urandom), 1'b0);
      x = led_o ^ INV;
      check("trap_uniform", (x == 5'h00) || (x == 5'h1f), 1'b1);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle();
      if (led_o == ~INV) found = 1'b1;
    end
    check("trap_goes_active", found, 1'b1);
    run = 0;
    while (led_o == ~INV && run < 20) begin
      idle();
      run++;
    end
    check("trap_half_period", run, 8);
    check("trap_sticky", trap_o, 1'b1);
`else
    check("trap_o_ignored", trap_o, 1'b0);
    repeat (40)
      step(($urandom % 3) == 0, 3'($urandom_range(0, 4)), 6'($urandom), 5'($urandom), 1'b0);
    check("trap_o_still_0", trap_o, 1'b0);
`endif

    // Asynchronous reset mid-operation
    rst_i = 1'b1;
    #1;
    check("async_rst_led", led_o, INV);
    check("async_rst_trap", trap_o, 1'b0);
    do_reset();
    repeat (30) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_led_ctrl.md
# gpio_led_ctrl

Parametrised LED/GPIO output controller placed between the soft-core system's GPIO register and the board LED pins. Each of `N_CH` channels has its own runtime mode: off, direct GPIO follow, PWM dimming, or timed blink. Per-channel output polarity is fixed at build time. An optional sticky trap indicator overrides all channels with a common blink pattern once the CPU traps.

## Interface

- `N_CH`, 5, number of LED channels (1..32).
- `PWM_BITS`, 8, PWM counter and level width (2..16).
- `PRESCALE_DIV`, 125000, clock cycles per blink tick (≥2; 1 ms at 125 MHz).
- `INV_MASK`, 5'b01100, per-channel output inversion; bit set = active-low pin.
- `TRAP_HALF`, 250, trap blink half-period in ticks (≥1).

- `clk_i`, in, 1, system clock.
- `rst_i`, in, 1, reset; asynchronous, active-high.
- `wr_en_i`, in, 1, config write strobe, single-cycle.
- `wr_ch_i`, in, `$clog2(N_CH)` (min 1), target channel.
- `wr_data_i`, in, `PWM_BITS+2`:
  - [1:0] mode.
  - [PWM_BITS+1:2] level.
- `gpio_i`, in, `N_CH`, direct-mode sources, already in the `clk_i` domain.
- `trap_i`, in, 1, CPU trap flag, same domain.
- `led_o`, out, `N_CH`, pin drive, registered.
- `trap_o`, out, 1, latched trap flag, registered.

## Operation

- Per-channel config register: mode[1:0] and level[PWM_BITS-1:0].
  - Reset: mode=OFF, level=0.
  - Write: on `wr_en_i`, channel `wr_ch_i` takes `wr_data_i`.
  - A write with `wr_ch_i ≥ N_CH` is ignored.
- Internal active bit per channel, selected by mode:
  - 0 OFF: active=0.
  - 1 DIRECT: active=`gpio_i[ch]`.
  - 2 PWM: active = (`pwm_cnt` < level).
    - `pwm_cnt` is a shared free-running `PWM_BITS` counter that increments every cycle and wraps.
    - level 0 → always off.
    - level 2^PWM_BITS−1 → on for all but one cycle per period.
  - 3 BLINK: per-channel tick counter and phase bit.
    - On each tick: if counter==level, phase toggles and the counter clears; otherwise the counter increments.
    - Half-period = level+1 ticks; level 0 → toggle every tick.
    - active=phase.
- Any write that sets a channel to BLINK clears that channel's counter and phase (phase=0, LED inactive). A rewrite with identical data also restarts the blink.
- Prescaler: counts 0..`PRESCALE_DIV`−1 and emits a one-cycle tick at wrap. It is shared by all channels and the trap blink, and free-running from reset.
- Output: `led_o[ch]` = final_active[ch] XOR `INV_MASK[ch]`, registered.
- Trap override (when compiled in):
  - `trap_i` high sets the sticky flag `trap_o`.
  - Only `rst_i` clears it.
  - While the flag is set, final_active for every channel = `trap_phase`.
    - `trap_phase` toggles every `TRAP_HALF` ticks.
    - `trap_phase` and its counter are held at 0 until the flag sets, then start from 0.
  - Channel configs keep updating underneath the override.

## Timing

- Reset values:
  - `led_o` = `INV_MASK` (all inactive).
  - `trap_o`=0.
  - `pwm_cnt`, prescaler, blink and trap counters, and phases all 0.
- Write latency: a config written in cycle n controls the active bit computed in cycle n+1, which appears on `led_o` at n+2.
- DIRECT latency: `gpio_i` to `led_o` is 1 cycle.
- PWM: `led_o` reflects the `pwm_cnt` value of the previous cycle (1-cycle registration). Period = 2^PWM_BITS cycles.
- Trap:
  - `trap_i` in cycle n → `trap_o`=1 at n+1.
  - All `led_o` forced to the inactive level at n+2, since `trap_phase`=0.
- Simultaneous write and `trap_i` in the same cycle: both take effect; the override governs `led_o`.
- Mid-operation `rst_i` assertion: immediate return to reset values, including a latched trap.
- No handshake or backpressure: every write is accepted in a single cycle.

## Configuration

- Macro: `GPIO_LED_CTRL_TRAP_OVERRIDE_EN`.
- Defined: trap latch, trap blink counter and override are implemented as described above.
- Undefined:
  - `trap_i` is ignored and `trap_o` is tied 0.
  - No trap counter logic is synthesised.
  - Channel behaviour is otherwise identical.

## Test plan

Bench parameters: `N_CH`=5, `PWM_BITS`=4, `PRESCALE_DIV`=4, `TRAP_HALF`=2, `INV_MASK`=5'b01100, macro defined unless stated.

- Reset, no writes → `led_o`=5'b01100 and `trap_o`=0 for 100 cycles.
- Write ch0 DIRECT; toggle `gpio_i[0]` 0→1 at cycle n → `led_o[0]`=1 at n+1. Write ch2 DIRECT; drive `gpio_i[2]`=1 → `led_o[2]`=0.
- Write ch1 PWM with level 5 → exactly 5 cycles high per 16-cycle period on `led_o[1]`. Level 0 → constant 0. Level 15 → 15 of 16 cycles high.
- Write ch3 BLINK with level 1 → `led_o[3]` inverted square wave, 8 cycles per half-period. Rewrite mid-period → phase restarts at inactive.
- Write with `wr_ch_i`=6 → no change to any channel.
- Pulse `trap_i` for 1 cycle → `trap_o` sticky. Every `led_o` bit then toggles together every 8 cycles, starting from inactive. Assert `rst_i` → `led_o`=5'b01100 and `trap_o`=0 immediately. Repeat with the macro undefined → `trap_o` stays 0 and no override occurs.
